n1_pbus_fetch: RTL and testbench

Program bus fetch sequencer for the N1 core. It drives the pipelined Wishbone control signals of the program bus and steers the hold and select controls of the program bus AGU (N1_pagu). It re-issues the captured fetch address on stall and retry. It delivers fetched opcodes to the instruction register with a single-cycle valid strobe. It sits between the flow controller, N1_pagu and the external program memory, and allows one outstanding transfer.

---
 rtl/n1_pbus_fetch.sv | 132 +++++++++++++
 tb/tb_n1_pbus_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/n1_pbus_fetch.sv
// N1 program bus fetch sequencer: drives pipelined Wishbone cyc/stb, steers the
// program AGU hold/select, re-issues on stall/retry and delivers opcodes to the IR.
module n1_pbus_fetch #(
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic        clk_i,
    input  logic        async_rst_i,
    input  logic        sync_rst_i,
    output logic        pbus_cyc_o,
    output logic        pbus_stb_o,
    input  logic        pbus_ack_i,
    input  logic        pbus_err_i,
    input  logic        pbus_rty_i,
    input  logic        pbus_stall_i,
    input  logic [15:0] pbus_dat_i,
    input  logic        fc2pf_req_i,
    output logic        pf2fc_busy_o,
    output logic        pf2fc_err_o,
    output logic        pf2pagu_prev_adr_hold_o,
    output logic        pf2pagu_prev_adr_sel_o,
    output logic        pf2ir_vld_o,
    output logic [15:0] pf2ir_dat_o,
    output logic [1:0]  prb_pf_state_o,
    output logic [3:0]  prb_pf_rty_cnt_o
);

    localparam logic [3:0] LP_RTY_MAX = RETRY_MAX[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RREQ = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_rty_cnt, w_rty_cnt_nxt;
    logic [15:0] r_dat, w_dat_nxt;
    logic        r_vld, w_vld_nxt;
    logic        r_err, w_err_nxt;
    logic        r_cyc, r_stb, r_hold, r_sel, r_busy;

    always_comb begin
        w_state_nxt   = r_state;
        w_rty_cnt_nxt = r_rty_cnt;
        w_vld_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_dat_nxt     = r_dat;
        case (r_state)
            S_IDLE: begin
                if (fc2pf_req_i) begin
                    w_state_nxt   = S_REQ;
                    w_rty_cnt_nxt = '0;
                end
            end
            S_REQ, S_RREQ: begin
                w_state_nxt = pbus_stall_i ? S_RREQ : S_WAIT;
            end
            S_WAIT: begin
                // Response priority: err over rty over ack
                if (pbus_err_i) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (pbus_rty_i) begin
                    if (r_rty_cnt < LP_RTY_MAX) begin
                        w_rty_cnt_nxt = r_rty_cnt + 4'd1;
                        w_state_nxt   = S_RREQ;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (pbus_ack_i) begin
                    w_vld_nxt = 1'b1;
                    w_dat_nxt = pbus_dat_i;
                    if (fc2pf_req_i) begin
                        w_state_nxt   = S_REQ;
                        w_rty_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Synchronous reset folded into next-state so both resets share one flop path
        if (sync_rst_i) begin
            w_state_nxt   = S_IDLE;
            w_rty_cnt_nxt = '0;
            w_vld_nxt     = 1'b0;
            w_err_nxt     = 1'b0;
            w_dat_nxt     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_state   <= S_IDLE;
            r_rty_cnt <= '0;
            r_dat     <= '0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_hold    <= 1'b0;
            r_sel     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rty_cnt <= w_rty_cnt_nxt;
            r_dat     <= w_dat_nxt;
            r_vld     <= w_vld_nxt;
            r_err     <= w_err_nxt;
            r_cyc     <= (w_state_nxt != S_IDLE);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_stb     <= (w_state_nxt == S_REQ)  || (w_state_nxt == S_RREQ);
            r_hold    <= (w_state_nxt == S_RREQ) || (w_state_nxt == S_WAIT);
            r_sel     <= (w_state_nxt == S_RREQ) || (w_state_nxt == S_WAIT);
        end
    end

    assign pbus_cyc_o              = r_cyc;
    assign pbus_stb_o              = r_stb;
    assign pf2fc_busy_o            = r_busy;
    assign pf2fc_err_o             = r_err;
    assign pf2pagu_prev_adr_hold_o = r_hold;
    assign pf2pagu_prev_adr_sel_o  = r_sel;
    assign pf2ir_vld_o             = r_vld;
    assign pf2ir_dat_o             = r_dat;
    assign prb_pf_state_o          = r_state;
    assign prb_pf_rty_cnt_o        = r_rty_cnt;

endmodule

// File: tb/tb_n1_pbus_fetch.sv
// Directed bench for n1_pbus_fetch with a small AGU previous-address model.
module tb_n1_pbus_fetch;

    logic        clk = 1'b0;
    logic        async_rst, sync_rst;
    logic        cyc, stb, ack, err, rty, stall;
    logic [15:0] dat_in, ir_dat;
    logic        req, busy, perr, hold, sel, vld;
    logic [1:0]  st;
    logic [3:0]  cnt;

    logic [15:0] agu_out = 16'h0000;
    logic [15:0] agu_prev = 16'h0000;
    logic [15:0] adr;

    int n_chk = 0;
    int n_fail = 0;
    logic [1:0]  prev_st = 2'd0;
    logic [15:0] prev_adr = 16'h0000;

    always #5 clk = ~clk;

    n1_pbus_fetch #(.RETRY_MAX(3)) dut (
        .clk_i(clk), .async_rst_i(async_rst), .sync_rst_i(sync_rst),
        .pbus_cyc_o(cyc), .pbus_stb_o(stb), .pbus_ack_i(ack), .pbus_err_i(err),
        .pbus_rty_i(rty), .pbus_stall_i(stall), .pbus_dat_i(dat_in),
        .fc2pf_req_i(req), .pf2fc_busy_o(busy), .pf2fc_err_o(perr),
        .pf2pagu_prev_adr_hold_o(hold), .pf2pagu_prev_adr_sel_o(sel),
        .pf2ir_vld_o(vld), .pf2ir_dat_o(ir_dat),
        .prb_pf_state_o(st), .prb_pf_rty_cnt_o(cnt)
    );

    // N1_pagu previous-address register and output mux
    always @(posedge clk) if (!hold) agu_prev <= agu_out;
    assign adr = sel ? agu_prev : agu_out;

    typedef struct {
        logic        req, ack, err, rty, stall;
        logic [15:0] dat;
        logic [1:0]  st;
        logic        vld, perr;
        logic [15:0] odat;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rq, a, e, r, s, input logic [15:0] d,
                                input logic [1:0] xs, input logic xv, xe,
                                input logic [15:0] xd, input logic [3:0] xc);
        vec_t v;
        v.req = rq; v.ack = a; v.err = e; v.rty = r; v.stall = s; v.dat = d;
        v.st = xs; v.vld = xv; v.perr = xe; v.odat = xd; v.cnt = xc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [1:0] xs);
        chk({name, ".state"}, st, xs);
        chk({name, ".cyc"},  cyc,  xs != 2'd0);
        chk({name, ".busy"}, busy, xs != 2'd0);
        chk({name, ".stb"},  stb,  (xs == 2'd1) || (xs == 2'd2));
        chk({name, ".hold"}, hold, (xs == 2'd2) || (xs == 2'd3));
        chk({name, ".sel"},  sel,  (xs == 2'd2) || (xs == 2'd3));
    endtask

    // One clock: drive inputs, sample #1 after the edge, run cycle-level invariants
    task automatic step(input logic rq, a, e, r, s, input logic [15:0] d);
        req = rq; ack = a; err = e; rty = r; stall = s; dat_in = d;
        @(posedge clk);
        #1;
        chk("vld_err_excl", {31'd0, vld & perr}, 32'd0);
        if ((st == 2'd2 || st == 2'd3) && prev_st != 2'd0)
            chk("adr_stable", {16'd0, adr}, {16'd0, prev_adr});
        prev_st  = st;
        prev_adr = adr;
    endtask

    initial begin
        async_rst = 1'b1; sync_rst = 1'b0;
        req = 0; ack = 0; err = 0; rty = 0; stall = 0; dat_in = '0;
        #12;
        chk_state("reset", 2'd0);
        chk("reset.vld", vld, 0);
        chk("reset.err", perr, 0);
        chk("reset.dat", ir_dat, 16'h0000);
        chk("reset.cnt", cnt, 0);
        async_rst = 1'b0;

        // single fetch, retry-then-ack, ack+err, ignored responses, rty+ack
        tbl.push_back(mk(1,0,0,0,0,16'h0000, 2'd1,0,0,16'h0000,0));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd3,0,0,16'h0000,0));
        tbl.push_back(mk(0,1,0,0,0,16'hABCD, 2'd0,1,0,16'hABCD,0));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd0,0,0,16'hABCD,0));
        tbl.push_back(mk(1,0,0,0,0,16'h0000, 2'd1,0,0,16'hABCD,0));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd3,0,0,16'hABCD,0));
        tbl.push_back(mk(0,0,0,1,0,16'h0000, 2'd2,0,0,16'hABCD,1));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd3,0,0,16'hABCD,1));
        tbl.push_back(mk(0,1,0,0,0,16'h5555, 2'd0,1,0,16'h5555,1));
        tbl.push_back(mk(1,0,0,0,0,16'h0000, 2'd1,0,0,16'h5555,0));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd3,0,0,16'h5555,0));
        tbl.push_back(mk(0,1,1,0,0,16'h9999, 2'd0,0,1,16'h5555,0));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd0,0,0,16'h5555,0));
        tbl.push_back(mk(1,1,0,0,0,16'h7777, 2'd1,0,0,16'h5555,0));
        tbl.push_back(mk(0,1,0,0,0,16'h7777, 2'd3,0,0,16'h5555,0));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd3,0,0,16'h5555,0));
        tbl.push_back(mk(0,1,0,0,0,16'h1111, 2'd0,1,0,16'h1111,0));
        tbl.push_back(mk(1,0,0,0,0,16'h0000, 2'd1,0,0,16'h1111,0));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd3,0,0,16'h1111,0));
        tbl.push_back(mk(0,1,0,1,0,16'h2222, 2'd2,0,0,16'h1111,1));
        tbl.push_back(mk(0,0,0,0,0,16'h0000, 2'd3,0,0,16'h1111,1));
        tbl.push_back(mk(0,1,0,0,0,16'h3333, 2'd0,1,0,16'h3333,1));

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            step(tbl[i].req, tbl[i].ack, tbl[i].err, tbl[i].rty, tbl[i].stall, tbl[i].dat);
            chk_state(nm, tbl[i].st);
            chk({nm, ".vld"}, vld, tbl[i].vld);
            chk({nm, ".err"}, perr, tbl[i].perr);
            chk({nm, ".dat"}, ir_dat, tbl[i].odat);
            chk({nm, ".cnt"}, cnt, tbl[i].cnt);
        end

        // stall for 3 cycles while the AGU moves on
        agu_out = 16'h1234;
        step(1,0,0,0,0,16'h0);
        chk_state("stall.req", 2'd1);
        chk("stall.adr_req", adr, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step(0,0,0,0,1,16'h0);
            agu_out = 16'hFFFF;
            chk_state($sformatf("stall.rreq%0d", i), 2'd2);
            chk($sformatf("stall.adr%0d", i), adr, 16'h1234);
        end
        step(0,0,0,0,0,16'h0);
        chk_state("stall.wait", 2'd3);
        chk("stall.adr_wait", adr, 16'h1234);
        step(0,1,0,0,0,16'h2222);
        chk_state("stall.done", 2'd0);
        chk("stall.vld", vld, 1);
        chk("stall.dat", ir_dat, 16'h2222);

        // retry limit: rty on every response
        step(1,0,0,0,0,16'h0);
        step(0,0,0,0,0,16'h0);
        chk_state("rmax.wait0", 2'd3);
        for (int i = 1; i <= 3; i++) begin
            step(0,1,0,1,0,16'hDEAD);
            chk_state($sformatf("rmax.rreq%0d", i), 2'd2);
            chk($sformatf("rmax.cnt%0d", i), cnt, 4'(i));
            chk($sformatf("rmax.vld%0d", i), vld, 0);
            step(0,0,0,0,0,16'h0);
            chk_state($sformatf("rmax.wait%0d", i), 2'd3);
        end
        step(0,0,0,1,0,16'h0);
        chk_state("rmax.end", 2'd0);
        chk("rmax.err", perr, 1);
        chk("rmax.vld", vld, 0);
        chk("rmax.cnt", cnt, 3);
        chk("rmax.dat", ir_dat, 16'h2222);
        step(0,0,0,0,0,16'h0);
        chk("rmax.err_once", perr, 0);

        // back-to-back fetches with req held high
        agu_out = 16'h0100;
        step(1,0,0,0,0,16'h0);
        chk_state("b2b.req0", 2'd1);
        for (int k = 0; k < 4; k++) begin
            step(1,0,0,0,0,16'h0);
            chk_state($sformatf("b2b.wait%0d", k), 2'd3);
            chk($sformatf("b2b.novld%0d", k), vld, 0);
            agu_out = 16'h0101 + 16'(k);
            step(1,1,0,0,0,16'hC000 + 16'(k));
            chk_state($sformatf("b2b.req%0d", k + 1), 2'd1);
            chk($sformatf("b2b.vld%0d", k), vld, 1);
            chk($sformatf("b2b.dat%0d", k), ir_dat, 16'hC000 + 16'(k));
        end
        step(0,0,0,0,0,16'h0);
        chk_state("b2b.last_wait", 2'd3);

        // async reset in WAIT
        #2 async_rst = 1'b1;
        #1;
        chk_state("arst.imm", 2'd0);
        chk("arst.vld", vld, 0);
        chk("arst.dat", ir_dat, 16'h0000);
        step(0,1,0,0,0,16'hBEEF);
        chk("arst.vld_held", vld, 0);
        chk_state("arst.held", 2'd0);
        async_rst = 1'b0;

        // sync reset in WAIT with a simultaneous ack
        step(1,0,0,0,0,16'h0);
        step(0,0,0,0,0,16'h0);
        chk_state("srst.wait", 2'd3);
        sync_rst = 1'b1;
        step(0,1,0,0,0,16'hBEEF);
        chk_state("srst.idle", 2'd0);
        chk("srst.vld", vld, 0);
        chk("srst.err", perr, 0);
        chk("srst.dat", ir_dat, 16'h0000);
        sync_rst = 1'b0;
        step(0,0,0,0,0,16'h0);
        chk("srst.after_vld", vld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
